// File: rtl/id_stage_fwd_pkg.sv
// RV32I encoding constants and command codes shared by the decode stage.
// The command code fits in 6 bits; 0 is the NOP / killed-op code.
package id_stage_fwd_pkg;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;

    typedef enum logic [5:0] {
        CmdNOP = 6'd0,
        CmdLUI, CmdAUIPC, CmdJAL, CmdJALR,
        CmdBEQ, CmdBNE, CmdBLT, CmdBGE, CmdBLTU, CmdBGEU,
        CmdLB, CmdLH, CmdLW, CmdLBU, CmdLHU,
        CmdSB, CmdSH, CmdSW,
        CmdADDI, CmdSLTI, CmdSLTIU, CmdXORI, CmdORI, CmdANDI,
        CmdSLLI, CmdSRLI, CmdSRAI,
        CmdADD, CmdSUB, CmdSLL, CmdSLT, CmdSLTU, CmdXOR,
        CmdSRL, CmdSRA, CmdOR, CmdAND
    } cmd_e;

endpackage

// File: rtl/id_stage_fwd_if.sv
// Bus bundle around the decode stage: IF/ID input, regfile ports, forwarding
// sources and the ID/EX output. master = surrounding pipeline, slave = stage.
interface id_stage_fwd_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CMD_W   = 6,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
);
    logic                          flush_in;
    logic                          in_valid;
    logic                          in_ready;
    logic [XLEN-1:0]               in_pc;
    logic [31:0]                   in_instru;
    logic                          reg1_read;
    logic [RA_W-1:0]               reg1addr;
    logic                          reg2_read;
    logic [RA_W-1:0]               reg2addr;
    logic [XLEN-1:0]               reg1_data;
    logic [XLEN-1:0]               reg2_data;
    logic [NUM_FWD-1:0]            fwd_valid;
    logic [NUM_FWD-1:0]            fwd_is_load;
    logic [NUM_FWD-1:0][RA_W-1:0]  fwd_addr;
    logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [XLEN-1:0]               out_reg1;
    logic [XLEN-1:0]               out_reg2;
    logic [RA_W-1:0]               out_rd;
    logic                          out_we;
    logic [CMD_W-1:0]              out_cmd;
    logic [XLEN-1:0]               out_imm;
    logic [XLEN-1:0]               out_pc;
    logic                          out_illegal;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        output flush_in, in_valid, in_pc, in_instru, reg1_data, reg2_data,
               fwd_valid, fwd_is_load, fwd_addr, fwd_data, out_ready,
        input  in_ready, reg1_read, reg1addr, reg2_read, reg2addr, out_valid,
               out_reg1, out_reg2, out_rd, out_we, out_cmd, out_imm, out_pc,
               out_illegal, stall_cnt
    );

    modport slave (
        input  flush_in, in_valid, in_pc, in_instru, reg1_data, reg2_data,
               fwd_valid, fwd_is_load, fwd_addr, fwd_data, out_ready,
        output in_ready, reg1_read, reg1addr, reg2_read, reg2addr, out_valid,
               out_reg1, out_reg2, out_rd, out_we, out_cmd, out_imm, out_pc,
               out_illegal, stall_cnt
    );
endinterface

// File: rtl/id_stage_fwd_decoder.sv
// Combinational RV32I decoder: command, immediate, rd/we and source operands.
// Any illegal encoding collapses to an all-zero op with only illegal set.
module id_decoder
    import id_stage_fwd_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [31:0]     instru,
    output cmd_e            cmd,
    output logic [XLEN-1:0] imm,
    output logic [RA_W-1:0] rd,
    output logic            we,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            illegal
);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm32, i_imm, shamt;
    cmd_e        c;
    logic        w, u1, u2, bad;

    assign op    = instru[6:0];
    assign f3    = instru[14:12];
    assign f7    = instru[31:25];
    assign i_imm = {{20{instru[31]}}, instru[31:20]};
    assign shamt = {26'b0, instru[25:20]};

    always_comb begin
        c = CmdNOP; imm32 = '0; w = 1'b0; u1 = 1'b0; u2 = 1'b0; bad = 1'b0;
        case (op)
            OP_LUI:   begin c = CmdLUI;   imm32 = {instru[31:12], 12'b0}; w = 1'b1; end
            OP_AUIPC: begin c = CmdAUIPC; imm32 = {instru[31:12], 12'b0}; w = 1'b1; end
            OP_JAL: begin
                c = CmdJAL; w = 1'b1;
                imm32 = {{11{instru[31]}}, instru[31], instru[19:12], instru[20], instru[30:21], 1'b0};
            end
            OP_JALR: begin
                c = CmdJALR; imm32 = i_imm; w = 1'b1; u1 = 1'b1; bad = (f3 != 3'd0);
            end
            OP_BRANCH: begin
                u1 = 1'b1; u2 = 1'b1;
                imm32 = {{19{instru[31]}}, instru[31], instru[7], instru[30:25], instru[11:8], 1'b0};
                case (f3)
                    F3_BEQ:  c = CmdBEQ;
                    F3_BNE:  c = CmdBNE;
                    F3_BLT:  c = CmdBLT;
                    F3_BGE:  c = CmdBGE;
                    F3_BLTU: c = CmdBLTU;
                    F3_BGEU: c = CmdBGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                imm32 = i_imm; w = 1'b1; u1 = 1'b1;
                case (f3)
                    F3_B:    c = CmdLB;
                    F3_H:    c = CmdLH;
                    F3_W:    c = CmdLW;
                    F3_BU:   c = CmdLBU;
                    F3_HU:   c = CmdLHU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                u1 = 1'b1; u2 = 1'b1;
                imm32 = {{20{instru[31]}}, instru[31:25], instru[11:7]};
                case (f3)
                    F3_B:    c = CmdSB;
                    F3_H:    c = CmdSH;
                    F3_W:    c = CmdSW;
                    default: bad = 1'b1;
                endcase
            end
            OP_ALU_IMM: begin
                imm32 = i_imm; w = 1'b1; u1 = 1'b1;
                case (f3)
                    F3_ADD:  c = CmdADDI;
                    F3_SLT:  c = CmdSLTI;
                    F3_SLTU: c = CmdSLTIU;
                    F3_XOR:  c = CmdXORI;
                    F3_OR:   c = CmdORI;
                    F3_AND:  c = CmdANDI;
                    // shamt[5] lives in f7[0], so a non-exact f7 also rejects 64-bit shifts
                    F3_SLL: begin
                        c = CmdSLLI; imm32 = shamt; bad = (f7 != F7_BASE);
                    end
                    default: begin
                        imm32 = shamt;
                        if (f7 == F7_BASE)     c = CmdSRLI;
                        else if (f7 == F7_ALT) c = CmdSRAI;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OP_ALU: begin
                w = 1'b1; u1 = 1'b1; u2 = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  c = CmdADD;
                        F3_SLL:  c = CmdSLL;
                        F3_SLT:  c = CmdSLT;
                        F3_SLTU: c = CmdSLTU;
                        F3_XOR:  c = CmdXOR;
                        F3_SR:   c = CmdSRL;
                        F3_OR:   c = CmdOR;
                        default: c = CmdAND;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) c = CmdSUB;
                else if (f7 == F7_ALT && f3 == F3_SR)      c = CmdSRA;
                else                                       bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            c = CmdNOP; imm32 = '0; w = 1'b0; u1 = 1'b0; u2 = 1'b0;
        end
    end

    assign cmd     = c;
    assign imm     = XLEN'($signed(imm32));
    assign we      = w;
    assign illegal = bad;
    assign rd      = w  ? RA_W'(instru[RD_HI:RD_LO])   : '0;
    assign rs1     = u1 ? RA_W'(instru[RS1_HI:RS1_LO]) : '0;
    assign rs2     = u2 ? RA_W'(instru[RS2_HI:RS2_LO]) : '0;
    assign rs1_en  = u1;
    assign rs2_en  = u2;

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage with prioritised operand forwarding, load-use stall and the
// registered ID/EX boundary (valid/ready). Source 0 is youngest and wins.
module id_stage_fwd
    import id_stage_fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CMD_W   = 6,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    id_stage_fwd_if.slave bus
);
    cmd_e                  dec_cmd;
    logic [XLEN-1:0]       dec_imm;
    logic [RA_W-1:0]       dec_rd;
    logic                  dec_we, dec_illegal;
    logic [1:0][RA_W-1:0]  rs_addr;
    logic [1:0]            rs_en, haz;
    logic [1:0][XLEN-1:0]  rf_data, opnd;
    logic                  hazard, out_busy, in_ready, accept, stall_inc;

    logic                  out_valid, r_we, r_illegal;
    logic [XLEN-1:0]       r_reg1, r_reg2, r_imm, r_pc;
    logic [RA_W-1:0]       r_rd;
    logic [CMD_W-1:0]      r_cmd;
    logic [CNT_W-1:0]      r_stall;

    id_decoder #(.XLEN(XLEN), .RA_W(RA_W)) u_dec (
        .instru  (bus.in_instru),
        .cmd     (dec_cmd),
        .imm     (dec_imm),
        .rd      (dec_rd),
        .we      (dec_we),
        .rs1     (rs_addr[0]),
        .rs2     (rs_addr[1]),
        .rs1_en  (rs_en[0]),
        .rs2_en  (rs_en[1]),
        .illegal (dec_illegal)
    );

    assign bus.reg1_read = rs_en[0];
    assign bus.reg1addr  = rs_addr[0];
    assign bus.reg2_read = rs_en[1];
    assign bus.reg2addr  = rs_addr[1];
    assign rf_data[0]    = bus.reg1_data;
    assign rf_data[1]    = bus.reg2_data;

    // Scan oldest to youngest so the lowest matching index overrides the rest.
    always_comb begin
        opnd = '0;
        haz  = '0;
        for (int p = 0; p < 2; p++) begin
            opnd[p] = rf_data[p];
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (bus.fwd_valid[i] && bus.fwd_addr[i] == rs_addr[p]) begin
                    opnd[p] = bus.fwd_data[i];
                    haz[p]  = bus.fwd_is_load[i];
                end
            end
            if (rs_addr[p] == '0) begin
                opnd[p] = '0;
                haz[p]  = 1'b0;
            end
        end
    end

    assign hazard    = |haz;
    assign out_busy  = out_valid && !bus.out_ready;
    assign in_ready  = !hazard && !bus.flush_in && !out_busy;
    assign accept    = bus.in_valid && in_ready;
    assign stall_inc = bus.in_valid && hazard && !bus.flush_in && !out_busy;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid <= 1'b0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_cmd     <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
            r_stall   <= '0;
        end else begin
            if (bus.flush_in) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                r_reg1    <= opnd[0];
                r_reg2    <= opnd[1];
                r_rd      <= dec_rd;
                r_we      <= dec_we;
                r_cmd     <= CMD_W'(dec_cmd);
                r_imm     <= dec_imm;
                r_pc      <= bus.in_pc;
                r_illegal <= dec_illegal;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            if (stall_inc && r_stall != '1)
                r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_reg1    = r_reg1;
    assign bus.out_reg2    = r_reg2;
    assign bus.out_rd      = r_rd;
    assign bus.out_we      = r_we;
    assign bus.out_cmd     = r_cmd;
    assign bus.out_imm     = r_imm;
    assign bus.out_pc      = r_pc;
    assign bus.out_illegal = r_illegal;
    assign bus.stall_cnt   = r_stall;

endmodule
